// File: rtl/spi_slave_mem.sv
// spi_slave_mem: SPI target for a 32x8 register file.
//
// Command frames arrive LSB first, one bit per clk while CS is low:
//   bits [1:0]  mode  (mode[1]=1 write, mode[0]=1 incremental read)
//   bits [6:2]  address
//   bits [14:7] write data (don't-care for reads)
//
// Read data is returned LSB first on a registered MISO that idles at 0, so
// several targets can share a wired-OR return line.
//
// The slot numbering below assumes the default ADDR_W=5 / DATA_W=8 layout.
//
// Optional feature: define SPI_SLAVE_WRPROT_EN to add a write-protect input
// `wp`. When it is high at the final write slot, the write is dropped and
// frame_err pulses instead of wr_done.

module spi_slave_mem #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] MEM_INIT = 8'h00
) (
  input  logic clk,
  input  logic rst,
  input  logic CS,
  input  logic MOSI,
`ifdef SPI_SLAVE_WRPROT_EN
  input  logic wp,
`endif
  output logic MISO,
  output logic busy,
  output logic wr_done,
  output logic frame_err
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int FRAME_W = 2 + ADDR_W + DATA_W;
  localparam int BIT_W   = $clog2(DATA_W);
  // The shifter keeps the previous DATA_W-1 bits; together with the live MOSI
  // bit that is one full write-data byte, and also covers mode+address.
  localparam int SH_W    = DATA_W - 1;

  // Slot numbers, counted from 0 at the first clk edge with CS low.
  localparam logic [4:0] SLOT_ADDR     = 5'(ADDR_W + 1);         // last address bit
  localparam logic [4:0] SLOT_WDATA    = 5'(FRAME_W - 1);        // last write-data bit
  localparam logic [4:0] SLOT_RD_FIRST = 5'(ADDR_W + 4);         // first read-data bit
  localparam logic [4:0] SLOT_RD_END   = 5'(ADDR_W + 4 + DATA_W); // trailing zero slot
  // Burst words are DATA_W+2 slots: a leading zero, data, a trailing zero.
  localparam logic [3:0] WORD_LAST     = 4'(DATA_W + 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RD,
    S_BURST,
    S_WR_COMMIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;      // slot number of the next edge
  logic [3:0]          ws_q, ws_d;        // burst word slot of the next edge
  logic [SH_W-1:0]     sh_q, sh_d;        // most recent command bits, newest on top
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovf_q, ovf_d;      // burst ran past the top address
  logic                incr_q, incr_d;    // mode[0] of the current read
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                wr_done_q, wr_done_d;
  logic                frame_err_q, frame_err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic [DATA_W-1:0]   full_s;            // shifter plus the bit on MOSI this edge
  logic [ADDR_W-1:0]   cmd_addr_s;
  logic                cmd_wr_s;
  logic                cmd_incr_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic [BIT_W-1:0]    rd_sel_s;
  logic                rd_bit_s;
  logic                wr_block_s;

  assign full_s     = {MOSI, sh_q};
  // At the address slot the newest ADDR_W+2 bits are address and mode.
  assign cmd_addr_s = full_s[DATA_W-1 -: ADDR_W];
  assign cmd_wr_s   = full_s[DATA_W-1-ADDR_W];
  assign cmd_incr_s = full_s[DATA_W-2-ADDR_W];

`ifdef SPI_SLAVE_WRPROT_EN
  assign wr_block_s = wp;
`else
  assign wr_block_s = 1'b0;
`endif

  // Select the read-data bit for the current slot; past the top address reads are zero.
  always_comb begin
    if (ovf_q) begin
      rd_data_s = {DATA_W{1'b0}};
    end else begin
      rd_data_s = mem_q[addr_q];
    end
    if (state_q == S_BURST) begin
      rd_sel_s = BIT_W'({1'b0, ws_q} - 5'd1);
    end else begin
      rd_sel_s = BIT_W'(cnt_q - SLOT_RD_FIRST);
    end
    rd_bit_s = rd_data_s[rd_sel_s];
  end

  // Next-state, datapath and output decode for the frame FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ws_d        = ws_q;
    sh_d        = sh_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    incr_d      = incr_q;
    miso_d      = 1'b0;
    wr_done_d   = 1'b0;
    frame_err_d = 1'b0;
    mem_d       = mem_q;

    if (CS) begin
      // Deselect always ends the frame; only an unfinished command is an error.
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      ws_d    = 4'd0;
      ovf_d   = 1'b0;
      if (state_q == S_CMD) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Slot 0: first command bit.
          sh_d    = full_s[DATA_W-1:1];
          cnt_d   = 5'd1;
          state_d = S_CMD;
        end

        S_CMD: begin
          sh_d  = full_s[DATA_W-1:1];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == SLOT_ADDR) begin
            addr_d = cmd_addr_s;
            incr_d = cmd_incr_s;
            ovf_d  = 1'b0;
            if (cmd_wr_s) begin
              state_d = S_CMD;
            end else begin
              state_d = S_RD;
            end
          end else if (cnt_q == SLOT_WDATA) begin
            // Only writes stay in CMD this long; commit the whole byte at once.
            if (wr_block_s) begin
              frame_err_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              mem_d[addr_q] = full_s;
              wr_done_d     = 1'b1;
              state_d       = S_WR_COMMIT;
            end
          end else begin
            state_d = S_CMD;
          end
        end

        S_RD: begin
          if ((cnt_q >= SLOT_RD_FIRST) && (cnt_q < SLOT_RD_END)) begin
            miso_d = rd_bit_s;
          end else begin
            miso_d = 1'b0;
          end
          if (cnt_q == SLOT_RD_END) begin
            if (incr_q) begin
              state_d = S_BURST;
              ws_d    = 4'd0;
              if (addr_q == {ADDR_W{1'b1}}) begin
                ovf_d = 1'b1;
              end else begin
                addr_d = addr_q + ADDR_ONE;
              end
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end

        S_BURST: begin
          if ((ws_q != 4'd0) && (ws_q != WORD_LAST)) begin
            miso_d = rd_bit_s;
          end else begin
            miso_d = 1'b0;
          end
          if (ws_q == WORD_LAST) begin
            ws_d = 4'd0;
            // Address saturates at the top; later words read as zero.
            if (addr_q == {ADDR_W{1'b1}}) begin
              ovf_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            ws_d = ws_q + 4'd1;
          end
        end

        S_WR_COMMIT: begin
          state_d = S_DONE;
        end

        S_DONE: begin
          // Extra clocks with CS still low are ignored.
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      ws_q        <= 4'd0;
      sh_q        <= {SH_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      ovf_q       <= 1'b0;
      incr_q      <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ws_q        <= ws_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      ovf_q       <= ovf_d;
      incr_q      <= incr_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      wr_done_q   <= wr_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file; every word returns to MEM_INIT on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= MEM_INIT;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign MISO      = miso_q;
  assign busy      = busy_q;
  assign wr_done   = wr_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed testbench for spi_slave_mem. Inputs change 1ns after a rising
// edge, outputs are sampled at the same point, so the value seen after
// edge k is what the master observes for slot k.

module tb_spi_slave_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic CS = 1'b1;
  logic MOSI = 1'b0;
`ifdef SPI_SLAVE_WRPROT_EN
  logic wp = 1'b0;
`endif
  logic MISO;
  logic busy;
  logic wr_done;
  logic frame_err;

  int n_checks = 0;
  int n_fail = 0;

  logic miso_log [0:127];
  logic busy_log [0:127];
  int   wr_cnt;
  int   err_cnt;
  logic busy_end;
  logic miso_end;

  spi_slave_mem dut (
    .clk       (clk),
    .rst       (rst),
    .CS        (CS),
    .MOSI      (MOSI),
`ifdef SPI_SLAVE_WRPROT_EN
    .wp        (wp),
`endif
    .MISO      (MISO),
    .busy      (busy),
    .wr_done   (wr_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Run one frame of nslots slots with CS low, then deselect and idle one cycle.
  task automatic xfer(input logic [14:0] cmd, input int nslots);
    logic [14:0] sh;
    wr_cnt = 0;
    err_cnt = 0;
    for (int k = 0; k < nslots; k++) begin
      sh = cmd >> k;
      CS = 1'b0;
      MOSI = sh[0];
      @(posedge clk); #1;
      miso_log[k] = MISO;
      busy_log[k] = busy;
      if (wr_done) wr_cnt++;
      if (frame_err) err_cnt++;
    end
    CS = 1'b1;
    MOSI = 1'b0;
    @(posedge clk); #1;
    miso_end = MISO;
    busy_end = busy;
    if (wr_done) wr_cnt++;
    if (frame_err) err_cnt++;
    @(posedge clk); #1;
    if (wr_done) wr_cnt++;
    if (frame_err) err_cnt++;
  endtask

  // Assemble LSB-first byte from logged MISO starting at slot base.
  task automatic grab(input int base, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = {miso_log[base + i], b[7:1]};
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] b);
    xfer({8'h00, a, 2'b00}, 18);
    grab(9, b);
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    xfer({d, a, 2'b11}, 16);
  endtask

  task automatic test_reset;
    logic [7:0] b;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (wr_done !== 1'b0) begin n_fail++; $display("FAIL reset_wr_done: got %b expected 0", wr_done); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 32; a++) begin
      read_byte(5'(a), b);
      n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL reset_read addr %0d: got %h expected 00", a, b); end
      n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL reset_busy_end addr %0d: got %b expected 0", a, busy_end); end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] b;
    write_byte(5'd5, 8'hA7);
    n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wr_done_pulses: got %0d expected 1", wr_cnt); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL write_err: got %0d expected 0", err_cnt); end
    n_checks++; if (busy_log[14] !== 1'b1) begin n_fail++; $display("FAIL busy_slot14: got %b expected 1", busy_log[14]); end
    n_checks++; if (busy_log[15] !== 1'b0) begin n_fail++; $display("FAIL busy_done: got %b expected 0", busy_log[15]); end
    read_byte(5'd5, b);
    n_checks++; if (b !== 8'hA7) begin n_fail++; $display("FAIL read_addr5: got %h expected a7", b); end
    n_checks++; if (miso_log[8] !== 1'b0) begin n_fail++; $display("FAIL miso_slot8: got %b expected 0", miso_log[8]); end
    n_checks++; if (miso_log[17] !== 1'b0) begin n_fail++; $display("FAIL miso_slot17: got %b expected 0", miso_log[17]); end
    n_checks++; if (busy_log[16] !== 1'b1) begin n_fail++; $display("FAIL busy_slot16: got %b expected 1", busy_log[16]); end
    n_checks++; if (busy_log[17] !== 1'b0) begin n_fail++; $display("FAIL busy_slot17: got %b expected 0", busy_log[17]); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL read_err: got %0d expected 0", err_cnt); end
    // mode 2'b10 is also a write
    xfer({8'h3C, 5'd0, 2'b10}, 16);
    n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wr_mode10_pulses: got %0d expected 1", wr_cnt); end
    read_byte(5'd0, b);
    n_checks++; if (b !== 8'h3C) begin n_fail++; $display("FAIL read_addr0: got %h expected 3c", b); end
  endtask

  task automatic test_burst;
    logic [7:0] b;
    logic [7:0] exp_w [0:5];
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    write_byte(5'd28, 8'h11);
    write_byte(5'd29, 8'h22);
    write_byte(5'd30, 8'h33);
    write_byte(5'd31, 8'h44);
    xfer({8'h00, 5'd28, 2'b01}, 68);
    for (int w = 0; w < 6; w++) begin
      if (w == 0) grab(9, b);
      else grab(19 + 10 * (w - 1), b);
      n_checks++; if (b !== exp_w[w]) begin n_fail++; $display("FAIL burst_word %0d: got %h expected %h", w, b, exp_w[w]); end
    end
    n_checks++; if (miso_log[18] !== 1'b0) begin n_fail++; $display("FAIL burst_gap18: got %b expected 0", miso_log[18]); end
    n_checks++; if (miso_log[27] !== 1'b0) begin n_fail++; $display("FAIL burst_gap27: got %b expected 0", miso_log[27]); end
    n_checks++; if (busy_log[67] !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b expected 1", busy_log[67]); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b expected 0", busy_end); end
    n_checks++; if (miso_end !== 1'b0) begin n_fail++; $display("FAIL burst_miso_end: got %b expected 0", miso_end); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL burst_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_abort;
    logic [7:0] b;
    write_byte(5'd7, 8'h96);
    xfer({8'h3C, 5'd7, 2'b11}, 10);
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL abort_err: got %0d expected 1", err_cnt); end
    n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL abort_wr: got %0d expected 0", wr_cnt); end
    n_checks++; if (busy_end !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_end); end
    read_byte(5'd7, b);
    n_checks++; if (b !== 8'h96) begin n_fail++; $display("FAIL abort_read: got %h expected 96", b); end
    n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL after_abort_err: got %0d expected 0", err_cnt); end
    xfer({8'h00, 5'd7, 2'b00}, 4);
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL rd_abort_err: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    logic [14:0] cmd;
    logic [14:0] sh;
    cmd = {8'h00, 5'd5, 2'b00};
    for (int k = 0; k < 12; k++) begin
      sh = cmd >> k;
      CS = 1'b0;
      MOSI = sh[0];
      @(posedge clk); #1;
    end
    // slot 11 carries bit 2 of 8'hA7
    n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL mid_miso_before: got %b expected 1", MISO); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL mid_miso_rst: got %b expected 0", MISO); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_rst: got %b expected 0", busy); end
    CS = 1'b1;
    MOSI = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    read_byte(5'd5, b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL mid_mem5: got %h expected 00", b); end
    read_byte(5'd28, b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL mid_mem28: got %h expected 00", b); end
  endtask

`ifdef SPI_SLAVE_WRPROT_EN
  task automatic test_wrprot;
    logic [7:0] b;
    wp = 1'b1;
    write_byte(5'd3, 8'h5A);
    wp = 1'b0;
    n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL wp_err: got %0d expected 1", err_cnt); end
    n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL wp_wr: got %0d expected 0", wr_cnt); end
    read_byte(5'd3, b);
    n_checks++; if (b !== 8'h00) begin n_fail++; $display("FAIL wp_read: got %h expected 00", b); end
    write_byte(5'd3, 8'h5A);
    n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wp_off_wr: got %0d expected 1", wr_cnt); end
    read_byte(5'd3, b);
    n_checks++; if (b !== 8'h5A) begin n_fail++; $display("FAIL wp_off_read: got %h expected 5a", b); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_abort();
    test_reset_midframe();
`ifdef SPI_SLAVE_WRPROT_EN
    test_wrprot();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
